// File: rtl/commit_rob.sv
package commit_rob_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [5:0] cause;
        logic       valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [7:0]               op;
        logic [XLEN-1:0]          result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order commit.
// Latency: allocation ack is combinational; an entry is presentable the cycle after it is done.
// Backpressure: allocation refused while full or flushing; frees from commit only show next cycle.
module commit_rob
    import commit_rob_pkg::*;
#(
    // NR_ENTRIES must equal 2**TRANS_ID_BITS so ids double as buffer indices
    parameter int unsigned NR_ENTRIES      = 2**TRANS_ID_BITS,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         flush_i,
    input  scoreboard_entry_t                            decoded_instr_i,
    input  logic                                         decoded_instr_valid_i,
    output logic                                         decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                     alloc_trans_id_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]             wbdata_i,
    input  exception_t [NR_WB_PORTS-1:0]                 ex_i,
    input  logic [NR_WB_PORTS-1:0]                       wt_valid_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]      commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
    output logic                                         rob_full_o,
    output logic                                         rob_empty_o
);

    typedef logic [TRANS_ID_BITS-1:0] id_t;
    typedef logic [TRANS_ID_BITS:0]   cnt_t;

    logic [NR_ENTRIES-1:0] issued_q, issued_d;
    logic [NR_ENTRIES-1:0] done_q, done_d;
    scoreboard_entry_t     mem_q [NR_ENTRIES];
    scoreboard_entry_t     mem_d [NR_ENTRIES];
    id_t                   issue_ptr_q, issue_ptr_d;
    id_t                   commit_ptr_q, commit_ptr_d;
    cnt_t                  count_q, count_d;
    cnt_t                  pops;
    id_t                   cidx [NR_COMMIT_PORTS];
    logic                  alloc;

    // Full is taken from the registered count, so same-cycle retirement never opens a slot
    assign rob_full_o          = (count_q == cnt_t'(NR_ENTRIES));
    assign rob_empty_o         = (count_q == '0);
    assign alloc               = decoded_instr_valid_i && !rob_full_o && !flush_i;
    assign decoded_instr_ack_o = alloc;
    assign alloc_trans_id_o    = issue_ptr_q;

    // Present the oldest entries straight from registers; valid needs issued, done and in-range
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            cidx[i]                 = commit_ptr_q + id_t'(i);
            commit_instr_o[i]       = mem_q[cidx[i]];
            commit_instr_o[i].valid = issued_q[cidx[i]] && done_q[cidx[i]] && (cnt_t'(i) < count_q);
        end
    end

    // Next state: flush dominates; otherwise writeback, retire and allocate in one pass
    always_comb begin
        issued_d     = issued_q;
        done_d       = done_q;
        mem_d        = mem_q;
        issue_ptr_d  = issue_ptr_q;
        commit_ptr_d = commit_ptr_q;
        count_d      = count_q;
        pops         = '0;
        if (flush_i) begin
            issued_d     = '0;
            done_d       = '0;
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
        end else begin
            // Only entries issued before this edge and still pending accept a result;
            // an exception already recorded is never overwritten
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wt_valid_i[p] && issued_q[trans_id_i[p]] && !done_q[trans_id_i[p]]) begin
                    mem_d[trans_id_i[p]].result = wbdata_i[p];
                    done_d[trans_id_i[p]]       = 1'b1;
                    if (ex_i[p].valid && !mem_q[trans_id_i[p]].ex.valid) begin
                        mem_d[trans_id_i[p]].ex = ex_i[p];
                    end
                end
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (commit_ack_i[i]) begin
                    issued_d[cidx[i]] = 1'b0;
                    done_d[cidx[i]]   = 1'b0;
                    pops              = pops + cnt_t'(1);
                end
            end
            // A decode-time exception leaves nothing to wait for, so the entry is born done
            if (alloc) begin
                mem_d[issue_ptr_q]          = decoded_instr_i;
                mem_d[issue_ptr_q].trans_id = issue_ptr_q;
                mem_d[issue_ptr_q].result   = '0;
                issued_d[issue_ptr_q]       = 1'b1;
                done_d[issue_ptr_q]         = decoded_instr_i.ex.valid;
                issue_ptr_d                 = issue_ptr_q + id_t'(1);
            end
            commit_ptr_d = commit_ptr_q + id_t'(pops);
            count_d      = count_q + cnt_t'(alloc) - pops;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_q     <= '0;
            done_q       <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            issued_q     <= issued_d;
            done_q       <= done_d;
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
        end
    end

    // Payload storage; contents are only observed behind issued/done so no reset is needed
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    logic ack_prefix_ok, ack_valid_ok, wb_unique_ok;

    // Protocol legality of the commit and writeback interfaces
    always_comb begin
        ack_prefix_ok = 1'b1;
        ack_valid_ok  = 1'b1;
        wb_unique_ok  = 1'b1;
        for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i] && !commit_ack_i[i-1]) ack_prefix_ok = 1'b0;
        end
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i] && !commit_instr_o[i].valid) ack_valid_ok = 1'b0;
        end
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            for (int j = p + 1; j < NR_WB_PORTS; j++) begin
                if (wt_valid_i[p] && wt_valid_i[j] && (trans_id_i[p] == trans_id_i[j])) wb_unique_ok = 1'b0;
            end
        end
    end

    a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) ack_prefix_ok);
    a_ack_valid:  assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) ack_valid_ok);
    a_wb_unique:  assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) wb_unique_ok);

endmodule

// File: tb/tb_commit_rob.sv
module tb_commit_rob;
    import commit_rob_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    flush_i;
    scoreboard_entry_t       decoded_instr_i;
    logic                    decoded_instr_valid_i;
    logic                    decoded_instr_ack_o;
    logic [2:0]              alloc_trans_id_o;
    logic [3:0][2:0]         trans_id_i;
    logic [3:0][31:0]        wbdata_i;
    exception_t [3:0]        ex_i;
    logic [3:0]              wt_valid_i;
    scoreboard_entry_t [1:0] commit_instr_o;
    logic [1:0]              commit_ack_i;
    logic                    rob_full_o;
    logic                    rob_empty_o;

    commit_rob dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .decoded_instr_i       (decoded_instr_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .alloc_trans_id_o      (alloc_trans_id_o),
        .trans_id_i            (trans_id_i),
        .wbdata_i              (wbdata_i),
        .ex_i                  (ex_i),
        .wt_valid_i            (wt_valid_i),
        .commit_instr_o        (commit_instr_o),
        .commit_ack_i          (commit_ack_i),
        .rob_full_o            (rob_full_o),
        .rob_empty_o           (rob_empty_o)
    );

    always #5 clk_i = ~clk_i;

    // In-order list of live instructions, oldest first
    typedef struct {
        int          id;
        bit          done;
        logic [31:0] result;
        logic [31:0] pc;
        bit          exv;
        logic [5:0]  cause;
    } m_t;

    m_t mq[$];
    int next_id;
    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int pops;
        bit acc;
        m_t e;
        if (!rst_ni || flush_i) begin
            mq.delete();
            next_id = 0;
            return;
        end
        acc = decoded_instr_valid_i && (mq.size() < 8);
        for (int p = 0; p < 4; p++) begin
            if (wt_valid_i[p]) begin
                foreach (mq[k]) begin
                    if (mq[k].id == int'(trans_id_i[p]) && !mq[k].done) begin
                        mq[k].done   = 1'b1;
                        mq[k].result = wbdata_i[p];
                        if (ex_i[p].valid && !mq[k].exv) begin
                            mq[k].exv   = 1'b1;
                            mq[k].cause = ex_i[p].cause;
                        end
                    end
                end
            end
        end
        pops = 0;
        for (int p = 0; p < 2; p++) if (commit_ack_i[p]) pops++;
        repeat (pops) void'(mq.pop_front());
        if (acc) begin
            e.id     = next_id;
            e.done   = decoded_instr_i.ex.valid;
            e.result = 32'h0;
            e.pc     = decoded_instr_i.pc;
            e.exv    = decoded_instr_i.ex.valid;
            e.cause  = decoded_instr_i.ex.cause;
            mq.push_back(e);
            next_id = (next_id + 1) % 8;
        end
    endtask

    task automatic compare_all();
        int n;
        bit ev;
        n = mq.size();
        chk("ack", decoded_instr_ack_o, decoded_instr_valid_i && (n < 8) && !flush_i);
        chk("alloc_id", alloc_trans_id_o, next_id);
        chk("full", rob_full_o, n == 8);
        chk("empty", rob_empty_o, n == 0);
        for (int i = 0; i < 2; i++) begin
            ev = (i < n) && mq[i].done;
            chk($sformatf("p%0d_valid", i), commit_instr_o[i].valid, ev);
            if (i < n) begin
                chk($sformatf("p%0d_id", i), commit_instr_o[i].trans_id, mq[i].id);
                chk($sformatf("p%0d_pc", i), commit_instr_o[i].pc, mq[i].pc);
            end
            if (ev) begin
                chk($sformatf("p%0d_result", i), commit_instr_o[i].result, mq[i].result);
                chk($sformatf("p%0d_exv", i), commit_instr_o[i].ex.valid, mq[i].exv);
                if (mq[i].exv) chk($sformatf("p%0d_cause", i), commit_instr_o[i].ex.cause, mq[i].cause);
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, resume just after it
    task automatic step();
        @(negedge clk_i);
        if (rst_ni) compare_all();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush_i               = 1'b0;
        decoded_instr_i       = '0;
        decoded_instr_valid_i = 1'b0;
        trans_id_i            = '0;
        wbdata_i              = '0;
        ex_i                  = '0;
        wt_valid_i            = '0;
        commit_ack_i          = '0;
    endtask

    // Junk trans_id/result in the request must be replaced by the buffer
    task automatic do_alloc(input logic [31:0] pc, input logic exv, input logic [5:0] cause);
        decoded_instr_i          = '0;
        decoded_instr_i.pc       = pc;
        decoded_instr_i.trans_id = 3'h7;
        decoded_instr_i.fu       = 4'h3;
        decoded_instr_i.op       = 8'h21;
        decoded_instr_i.result   = 32'hDEAD;
        decoded_instr_i.ex.valid = exv;
        decoded_instr_i.ex.cause = cause;
        decoded_instr_valid_i    = 1'b1;
    endtask

    task automatic do_wb(input int p, input logic [2:0] id, input logic [31:0] data,
                         input logic exv, input logic [5:0] cause);
        wt_valid_i[p]     = 1'b1;
        trans_id_i[p]     = id;
        wbdata_i[p]       = data;
        ex_i[p].valid     = exv;
        ex_i[p].cause     = cause;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        model_update();
        repeat (2) step();
        chk("rst_ack", decoded_instr_ack_o, 0);
        chk("rst_alloc_id", alloc_trans_id_o, 0);
        chk("rst_p0_valid", commit_instr_o[0].valid, 0);
        chk("rst_p1_valid", commit_instr_o[1].valid, 0);
        chk("rst_full", rob_full_o, 0);
        chk("rst_empty", rob_empty_o, 1);
        rst_ni = 1'b1;

        // Three allocations, out-of-order writeback
        for (int i = 0; i < 3; i++) begin
            idle(); do_alloc(32'h100 + 32'(4*i), 1'b0, 6'd0); step();
        end
        idle();
        chk("t1_alloc_id", alloc_trans_id_o, 3);
        do_wb(0, 3'd1, 32'hA, 1'b0, 6'd0); step(); idle();
        chk("t1_p0_wait", commit_instr_o[0].valid, 0);
        chk("t1_p1_valid", commit_instr_o[1].valid, 1);
        do_wb(2, 3'd0, 32'hB, 1'b0, 6'd0); step(); idle();
        chk("t1_p0_valid", commit_instr_o[0].valid, 1);
        chk("t1_p0_result", commit_instr_o[0].result, 32'hB);
        chk("t1_p0_id", commit_instr_o[0].trans_id, 0);
        chk("t1_p1_id", commit_instr_o[1].trans_id, 1);
        chk("t1_p1_result", commit_instr_o[1].result, 32'hA);

        // Retire two at once
        commit_ack_i = 2'b11; step(); idle();
        chk("t4_p0_id", commit_instr_o[0].trans_id, 2);
        chk("t4_p0_valid", commit_instr_o[0].valid, 0);
        chk("t4_p1_oob", commit_instr_o[1].valid, 0);
        chk("t4_empty", rob_empty_o, 0);
        do_wb(1, 3'd2, 32'hC, 1'b0, 6'd0); step(); idle();
        commit_ack_i = 2'b01; step(); idle();
        chk("t4_drained", rob_empty_o, 1);
        chk("t4_alloc_id", alloc_trans_id_o, 3);

        // Flush with five in flight plus a writeback, an ack and a request
        for (int i = 0; i < 5; i++) begin
            idle(); do_alloc(32'h180 + 32'(4*i), 1'b0, 6'd0); step();
        end
        idle(); do_wb(0, 3'd3, 32'h33, 1'b0, 6'd0); step(); idle();
        chk("t5_p0_id", commit_instr_o[0].trans_id, 3);
        flush_i = 1'b1;
        do_alloc(32'h1FC, 1'b0, 6'd0);
        do_wb(1, 3'd4, 32'h44, 1'b0, 6'd0);
        commit_ack_i = 2'b01;
        #1;
        chk("t5_flush_noack", decoded_instr_ack_o, 0);
        step(); idle();
        chk("t5_empty", rob_empty_o, 1);
        chk("t5_p0_valid", commit_instr_o[0].valid, 0);
        chk("t5_p1_valid", commit_instr_o[1].valid, 0);
        chk("t5_alloc_id", alloc_trans_id_o, 0);

        // Fill, reject while full even with a same-cycle retire, wrap to id 0
        for (int i = 0; i < 8; i++) begin
            idle(); do_alloc(32'h200 + 32'(4*i), 1'b0, 6'd0); step();
        end
        idle();
        chk("t2_full", rob_full_o, 1);
        do_alloc(32'h300, 1'b0, 6'd0);
        #1;
        chk("t2_reject", decoded_instr_ack_o, 0);
        step();
        do_wb(0, 3'd0, 32'h10, 1'b0, 6'd0); step();
        wt_valid_i = '0;
        do_wb(1, 3'd1, 32'h11, 1'b0, 6'd0);
        commit_ack_i = 2'b01;
        #1;
        chk("t2_reject_on_pop", decoded_instr_ack_o, 0);
        step();
        wt_valid_i = '0;
        commit_ack_i = 2'b01;
        #1;
        chk("t2_accept", decoded_instr_ack_o, 1);
        chk("t2_wrap_id", alloc_trans_id_o, 0);
        step(); idle();
        chk("t2_count_kept", rob_full_o, 0);
        chk("t2_next_id", alloc_trans_id_o, 1);
        chk("t2_p0_id", commit_instr_o[0].trans_id, 2);

        // Decode exception commits without writeback and keeps its cause
        flush_i = 1'b1; step(); idle();
        do_alloc(32'h400, 1'b1, 6'd12); step(); idle();
        chk("t3_p0_valid", commit_instr_o[0].valid, 1);
        chk("t3_cause", commit_instr_o[0].ex.cause, 12);
        do_wb(3, 3'd0, 32'h99, 1'b1, 6'd5);
        do_alloc(32'h404, 1'b0, 6'd0);
        step(); idle();
        chk("t3_cause_kept", commit_instr_o[0].ex.cause, 12);
        chk("t3_result_kept", commit_instr_o[0].result, 0);
        chk("t3_p1_wait", commit_instr_o[1].valid, 0);
        do_wb(2, 3'd1, 32'h77, 1'b1, 6'd5); step(); idle();
        chk("t3_p1_valid", commit_instr_o[1].valid, 1);
        chk("t3_p1_exv", commit_instr_o[1].ex.valid, 1);
        chk("t3_p1_cause", commit_instr_o[1].ex.cause, 5);
        chk("t3_p1_result", commit_instr_o[1].result, 32'h77);

        // Writeback racing the allocation of the same id is dropped
        flush_i = 1'b1; step(); idle();
        do_alloc(32'h500, 1'b0, 6'd0);
        do_wb(0, 3'd0, 32'h55, 1'b0, 6'd0);
        step(); idle();
        chk("t6_p0_valid", commit_instr_o[0].valid, 0);
        chk("t6_p0_result", commit_instr_o[0].result, 0);
        chk("t6_empty", rob_empty_o, 0);

        // Asynchronous reset mid-cycle
        flush_i = 1'b1; step(); idle();
        for (int i = 0; i < 4; i++) begin
            idle(); do_alloc(32'h600 + 32'(4*i), 1'b0, 6'd0); step();
        end
        idle();
        chk("t7_pre_alloc_id", alloc_trans_id_o, 4);
        #2;
        rst_ni = 1'b0;
        model_update();
        #1;
        chk("t7_empty", rob_empty_o, 1);
        chk("t7_full", rob_full_o, 0);
        chk("t7_p0_valid", commit_instr_o[0].valid, 0);
        chk("t7_alloc_id", alloc_trans_id_o, 0);
        chk("t7_ack", decoded_instr_ack_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        do_alloc(32'h700, 1'b0, 6'd0);
        #1;
        chk("t7_first_id", alloc_trans_id_o, 0);
        step(); idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_rob.md
Name: commit_rob

Overview:
- Circular reorder buffer that feeds the commit stage: it is the producer side of the commit_instr / commit_ack interface.
- Issue allocates entries in program order, each tagged with a transaction id.
- Functional-unit writeback marks entries done and stores result and exception.
- The oldest NR_COMMIT_PORTS entries are presented in order; each acknowledged entry retires.

Parameters:
- NR_ENTRIES, 8, buffer depth; must equal 2**TRANS_ID_BITS (power of two).
- NR_COMMIT_PORTS, 2, in-order commit ports presented; must be <= NR_ENTRIES.
- NR_WB_PORTS, 4, writeback ports from functional units.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop all in-flight entries
- decoded_instr_i  in  scoreboard_entry_t  instruction to allocate
- decoded_instr_valid_i  in  1  allocation request
- decoded_instr_ack_o  out  1  allocation accepted this cycle
- alloc_trans_id_o  out  TRANS_ID_BITS  id given to the entry allocated this cycle (current issue pointer)
- trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  writeback target id
- wbdata_i  in  NR_WB_PORTS x XLEN  writeback result
- ex_i  in  NR_WB_PORTS x exception_t  writeback exception
- wt_valid_i  in  NR_WB_PORTS  writeback valid
- commit_instr_o  out  NR_COMMIT_PORTS x scoreboard_entry_t  oldest entries, port 0 oldest
- commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledge
- rob_full_o  out  1  count == NR_ENTRIES
- rob_empty_o  out  1  count == 0

Behaviour:
- State:
  - Per entry: issued flag, done flag, scoreboard_entry_t payload.
  - issue_ptr and commit_ptr, TRANS_ID_BITS each, wrap modulo NR_ENTRIES.
  - count, TRANS_ID_BITS+1 bits.
- Reset (async, rst_ni low):
  - All flags 0; pointers 0; count 0.
  - Outputs: ack 0, alloc_trans_id_o 0, all commit_instr_o[i].valid 0, full 0, empty 1.
- Allocation:
  - decoded_instr_ack_o = decoded_instr_valid_i && !rob_full_o && !flush_i.
  - Combinational, same cycle. rob_full_o comes from the registered count, so a commit in the same cycle does not free space for allocation.
  - On ack, the entry at issue_ptr gets the payload with trans_id = issue_ptr, result 0, issued = 1; issue_ptr increments.
  - done = decoded_instr_i.ex.valid at allocation: a fetch/decode exception makes the entry immediately committable.
- Writeback, per port with wt_valid_i:
  - If the target entry is issued and not done: store wbdata_i into result and set done.
  - ex_i is stored only if ex_i.valid and the entry's ex.valid is 0; the earlier exception keeps precedence.
  - Writeback to a non-issued or already-done entry is ignored.
  - Two ports targeting the same id in one cycle is illegal (assertion).
- Commit presentation (combinational from registers):
  - commit_instr_o[i] = payload at commit_ptr+i (wrapping).
  - .valid = issued && done && (i < count).
- Commit acknowledge:
  - commit_ack_i must be a prefix: ack[i] implies ack[i-1]. Ack on an entry whose presented valid is 0 is illegal. Both are checked by assertion.
  - pops = popcount(commit_ack_i). Acked entries clear issued/done; commit_ptr += pops.
- Count:
  - count_next = count + alloc - pops.
  - Simultaneous alloc and pop at count == NR_ENTRIES-1: count unchanged.
  - Alloc at empty with writeback to that id in the same cycle: the writeback is ignored (entry not yet issued).
- Flush:
  - Synchronous, highest priority.
  - Clears all issued/done flags; pointers and count go to 0.
  - commit_ack_i and writebacks are ignored that cycle.
  - Outputs show empty the following cycle.
- No combinational path from commit_ack_i to any output.

Test Plan:
- Reset, then allocate 3 entries (ids 0,1,2); write back id 1 then id 0 with 0xA, 0xB -> port0 valid only after id 0 done, with result 0xB; port1 shows id 1, result 0xA.
- Fill 8 entries -> rob_full_o=1 and ack=0 on a 9th request. Ack port0 with a simultaneous request -> request still rejected that cycle, accepted next cycle with id 0 (wrap).
- Allocate an entry with decoded ex.valid=1, cause 12 -> commit_instr_o[0].valid=1 the next cycle with no writeback; a later writeback with cause 5 leaves cause 12.
- Entries 0,1 done; commit_ack_i=2'b11 -> commit_ptr=2, count reduced by 2; commit_ack_i=2'b10 -> assertion fires.
- 5 entries in flight; assert flush_i together with a writeback and an ack -> next cycle empty=1, all valid 0; the next allocation gets id 0.
- Assert rst_ni low mid-stream with 4 entries -> outputs immediately at reset values, independent of clock.
